pipe_adder_arbiter: RTL and testbench

Round-robin arbiter that shares one 32-bit, five-register-stage pipelined recursive-carry adder among `NREQ` requesters. Each cycle it grants at most one requester and steers that requester's operands onto the adder inputs. A tag shift register matched to the adder's latency returns each sum and carry-out to the requester that issued it. The block sits between the floating-point adder's mantissa/exponent units and the shared integer adder pipeline. The adder itself is instantiated outside this block.

---
 rtl/pipe_adder_arbiter_if.sv | 24 ++
 rtl/pipe_adder_arbiter.sv | 115 +++++++++++
 tb/tb_pipe_adder_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipe_adder_arbiter_if.sv
// Requester-side bus of the shared pipelined adder arbiter.
// master: requester cluster; slave: arbiter.
interface pipe_adder_arbiter_if #(
   parameter int unsigned NREQ = 4
);
   logic [NREQ-1:0]      req;
   logic [32*NREQ-1:0]   op_a;
   logic [32*NREQ-1:0]   op_b;
   logic [NREQ-1:0]      op_cin;
   logic [NREQ-1:0]      gnt;
   logic [NREQ-1:0]      res_valid;
   logic [31:0]          res_sum;
   logic                 res_cout;

   modport master (
      output req, op_a, op_b, op_cin,
      input  gnt, res_valid, res_sum, res_cout
   );

   modport slave (
      input  req, op_a, op_b, op_cin,
      output gnt, res_valid, res_sum, res_cout
   );
endinterface

// File: rtl/pipe_adder_arbiter.sv
// Round-robin arbiter sharing one LAT-stage pipelined 32-bit adder among NREQ
// requesters; a tag shift register routes each sum back to its issuer.
// Optional macro PIPE_ADDER_ARB_FIXED_PRIO_EN: fixed priority, lowest index wins.
module pipe_adder_arbiter #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned LAT  = 5
) (
   input  logic                       clk,
   input  logic                       clear,
   pipe_adder_arbiter_if.slave        bus,
   output logic [31:0]                add_a,
   output logic [31:0]                add_b,
   output logic                       add_cin,
   input  logic [31:0]                add_sum,
   input  logic                       add_cout,
   output logic [$clog2(LAT+1)-1:0]   inflight,
   output logic                       idle
);
   localparam int unsigned IDW = $clog2(NREQ);
   localparam int unsigned CW  = $clog2(LAT+1);

   logic             found;
   logic [IDW-1:0]   sel;
   logic [LAT-1:0]   tag_valid;
   logic [IDW-1:0]   tag_id [LAT];
   logic             retire;

`ifdef PIPE_ADDER_ARB_FIXED_PRIO_EN
   // Fixed-priority pick: lowest active index wins.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int unsigned j = 0; j < NREQ; j++) begin
         if (!found && bus.req[j]) begin
            found = 1'b1;
            sel   = IDW'(j);
         end
      end
      if (clear) found = 1'b0;
   end
`else
   logic [IDW-1:0]   ptr;
   logic [31:0]      scan;

   // Round-robin pick: first active request at or after ptr, wrapping.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      scan  = '0;
      for (int unsigned j = 0; j < NREQ; j++) begin
         scan = (32'(ptr) + 32'(j)) % 32'(NREQ);
         if (!found && bus.req[scan[IDW-1:0]]) begin
            found = 1'b1;
            sel   = scan[IDW-1:0];
         end
      end
      if (clear) found = 1'b0;
   end

   // Priority pointer advances past the winner; holds when nothing issues.
   always_ff @(posedge clk) begin
      if (clear) begin
         ptr <= '0;
      end else if (found) begin
         ptr <= (sel == IDW'(NREQ-1)) ? '0 : sel + 1'b1;
      end
   end
`endif

   assign bus.gnt = found ? (NREQ'(1) << sel) : '0;

   // Operand steering onto the shared adder; zero when nothing is granted.
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      if (found) begin
         add_a   = bus.op_a[{sel, 5'd0} +: 32];
         add_b   = bus.op_b[{sel, 5'd0} +: 32];
         add_cin = bus.op_cin[sel];
      end
   end

   // Tag pipeline matched to the adder latency; clear drops all outstanding tags.
   always_ff @(posedge clk) begin
      if (clear) begin
         tag_valid <= '0;
         for (int unsigned i = 0; i < LAT; i++) tag_id[i] <= '0;
      end else begin
         tag_valid <= {tag_valid[LAT-2:0], found};
         tag_id[0] <= sel;
         for (int unsigned i = 1; i < LAT; i++) tag_id[i] <= tag_id[i-1];
      end
   end

   assign retire        = tag_valid[LAT-1];
   assign bus.res_valid = retire ? (NREQ'(1) << tag_id[LAT-1]) : '0;
   assign bus.res_sum   = add_sum;
   assign bus.res_cout  = add_cout;

   // Outstanding-operation count: issue and retire in one cycle cancel.
   always_ff @(posedge clk) begin
      if (clear) begin
         inflight <= '0;
      end else begin
         case ({found, retire})
            2'b10:   inflight <= inflight + CW'(1);
            2'b01:   inflight <= inflight - CW'(1);
            default: inflight <= inflight;
         endcase
      end
   end

   assign idle = (inflight == '0) && (bus.req == '0);
endmodule

// File: tb/tb_pipe_adder_arbiter.sv
// Directed bench for pipe_adder_arbiter with a 5-stage behavioural adder.
module tb_pipe_adder_arbiter;
   localparam int unsigned NREQ = 4;
   localparam int unsigned LAT  = 5;

   logic        clk = 1'b0;
   logic        clear;
   logic [31:0] add_a, add_b, add_sum;
   logic        add_cin, add_cout;
   logic [2:0]  inflight;
   logic        idle;
   logic [32:0] apipe [LAT];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   pipe_adder_arbiter_if #(.NREQ(NREQ)) bus ();

   pipe_adder_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
      .clk(clk), .clear(clear), .bus(bus),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
      .add_sum(add_sum), .add_cout(add_cout),
      .inflight(inflight), .idle(idle)
   );

   // External adder: LAT register stages, never cleared.
   always_ff @(posedge clk) begin
      apipe[0] <= 33'(add_a) + 33'(add_b) + 33'(add_cin);
      for (int i = 1; i < LAT; i++) apipe[i] <= apipe[i-1];
   end
   assign add_sum  = apipe[LAT-1][31:0];
   assign add_cout = apipe[LAT-1][32];

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet_inputs();
      bus.req    = '0;
      bus.op_a   = '0;
      bus.op_b   = '0;
      bus.op_cin = '0;
   endtask

   task automatic do_clear();
      quiet_inputs();
      clear = 1'b1;
      cyc();
      clear = 1'b0;
   endtask

   task automatic test_reset();
      clear      = 1'b1;
      bus.req    = 4'b1111;
      bus.op_a   = {4{32'h1234_5678}};
      bus.op_b   = {4{32'h0000_0001}};
      bus.op_cin = 4'b1111;
      cyc();
      #1;
      checks++; if (bus.gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", bus.gnt); end
      checks++; if (add_a !== 32'h0 || add_b !== 32'h0 || add_cin !== 1'b0) begin errors++; $display("FAIL reset_add got %h %h %b exp 0", add_a, add_b, add_cin); end
      cyc();
      quiet_inputs();
      clear = 1'b0;
      #1;
      checks++; if (bus.res_valid !== 4'b0000) begin errors++; $display("FAIL reset_res_valid got %b exp 0000", bus.res_valid); end
      checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL reset_inflight got %0d exp 0", inflight); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b exp 1", idle); end
   endtask

   task automatic test_single();
      logic [3:0] exp_rv;
      do_clear();
      for (int c = 0; c <= 6; c++) begin
         if (c == 0) begin
            bus.req = 4'b0100;
            bus.op_a[64 +: 32] = 32'h5;
            bus.op_b[64 +: 32] = 32'h3;
         end else begin
            bus.req = 4'b0000;
         end
         #1;
         if (c == 0) begin
            checks++; if (bus.gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got %b exp 0100", bus.gnt); end
            checks++; if (add_a !== 32'h5 || add_b !== 32'h3) begin errors++; $display("FAIL single_steer got %h %h exp 5 3", add_a, add_b); end
         end
         exp_rv = (c == 5) ? 4'b0100 : 4'b0000;
         checks++; if (bus.res_valid !== exp_rv) begin errors++; $display("FAIL single_rv c%0d got %b exp %b", c, bus.res_valid, exp_rv); end
         if (c == 5) begin
            checks++; if (bus.res_sum !== 32'h8 || bus.res_cout !== 1'b0) begin errors++; $display("FAIL single_sum got %h %b exp 8 0", bus.res_sum, bus.res_cout); end
         end
         cyc();
      end
   endtask

   task automatic test_contention();
      int k;
      logic [3:0] exp_oh;
      logic [2:0] exp_inf;
      do_clear();
      for (int i = 0; i < 4; i++) begin
         bus.op_a[32*i +: 32] = 32'(i);
         bus.op_b[32*i +: 32] = 32'h10;
      end
      for (int c = 0; c <= 12; c++) begin
         bus.req = (c < 8) ? 4'b1111 : 4'b0000;
         #1;
         if (c < 8) begin
`ifdef PIPE_ADDER_ARB_FIXED_PRIO_EN
            k = 0;
`else
            k = c % 4;
`endif
            exp_oh = 4'b0001 << k;
            checks++; if (bus.gnt !== exp_oh) begin errors++; $display("FAIL cont_gnt c%0d got %b exp %b", c, bus.gnt, exp_oh); end
         end
         if (c >= 5) begin
`ifdef PIPE_ADDER_ARB_FIXED_PRIO_EN
            k = 0;
`else
            k = (c - 5) % 4;
`endif
            exp_oh = 4'b0001 << k;
            checks++; if (bus.res_valid !== exp_oh) begin errors++; $display("FAIL cont_rv c%0d got %b exp %b", c, bus.res_valid, exp_oh); end
            checks++; if (bus.res_sum !== 32'h10 + 32'(k)) begin errors++; $display("FAIL cont_sum c%0d got %h exp %h", c, bus.res_sum, 32'h10 + 32'(k)); end
         end
         exp_inf = (c <= 5) ? 3'(c) : (c <= 8) ? 3'd5 : 3'(13 - c);
         checks++; if (inflight !== exp_inf) begin errors++; $display("FAIL cont_inflight c%0d got %0d exp %0d", c, inflight, exp_inf); end
         checks++; if (idle !== 1'b0) begin errors++; $display("FAIL cont_idle c%0d got %b exp 0", c, idle); end
         cyc();
      end
   endtask

   task automatic test_carry();
      logic [31:0] va [3];
      logic [31:0] vb [3];
      logic        vc [3];
      logic [31:0] es [3];
      logic        ec [3];
      va[0] = 32'hFFFF_FFFF; vb[0] = 32'h1;          vc[0] = 1'b0; es[0] = 32'h0;         ec[0] = 1'b1;
      va[1] = 32'h0;         vb[1] = 32'h0;          vc[1] = 1'b1; es[1] = 32'h1;         ec[1] = 1'b0;
      va[2] = 32'hFFFF_FFFF; vb[2] = 32'hFFFF_FFFF;  vc[2] = 1'b1; es[2] = 32'hFFFF_FFFF; ec[2] = 1'b1;
      do_clear();
      for (int c = 0; c <= 7; c++) begin
         if (c < 3) begin
            bus.req          = 4'b0001;
            bus.op_a[31:0]   = va[c];
            bus.op_b[31:0]   = vb[c];
            bus.op_cin[0]    = vc[c];
         end else begin
            bus.req = 4'b0000;
         end
         #1;
         if (c >= 5) begin
            checks++; if (bus.res_valid !== 4'b0001) begin errors++; $display("FAIL carry_rv c%0d got %b exp 0001", c, bus.res_valid); end
            checks++; if (bus.res_sum !== es[c-5] || bus.res_cout !== ec[c-5]) begin errors++; $display("FAIL carry_sum c%0d got %h/%b exp %h/%b", c, bus.res_sum, bus.res_cout, es[c-5], ec[c-5]); end
         end
         cyc();
      end
   endtask

   task automatic test_clear_midflight();
      do_clear();
      for (int c = 0; c <= 9; c++) begin
         bus.req = (c < 3 || c == 9) ? 4'b1111 : 4'b0000;
         clear   = (c == 3);
         #1;
         if (c == 3) begin
            checks++; if (bus.gnt !== 4'b0000 || add_a !== 32'h0) begin errors++; $display("FAIL mid_clear_gnt got %b %h exp 0000 0", bus.gnt, add_a); end
         end
         if (c == 4) begin
            checks++; if (inflight !== 3'd0) begin errors++; $display("FAIL mid_inflight got %0d exp 0", inflight); end
            checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle got %b exp 1", idle); end
         end
         if (c >= 4 && c <= 8) begin
            checks++; if (bus.res_valid !== 4'b0000) begin errors++; $display("FAIL mid_rv c%0d got %b exp 0000", c, bus.res_valid); end
         end
         if (c == 9) begin
            checks++; if (bus.gnt !== 4'b0001) begin errors++; $display("FAIL mid_ptr_restart got %b exp 0001", bus.gnt); end
         end
         cyc();
      end
      clear = 1'b0;
      quiet_inputs();
   endtask

   task automatic test_sparse();
      logic [3:0] exp_rv;
      logic       exp_idle;
      do_clear();
      bus.op_b[32 +: 32] = 32'h1;
      for (int c = 0; c <= 10; c++) begin
         bus.req = (c == 0 || c == 3) ? 4'b0010 : 4'b0000;
         bus.op_a[32 +: 32] = 32'(c);
         #1;
         exp_rv   = (c == 5 || c == 8) ? 4'b0010 : 4'b0000;
         exp_idle = (c >= 9);
         checks++; if (bus.res_valid !== exp_rv) begin errors++; $display("FAIL sparse_rv c%0d got %b exp %b", c, bus.res_valid, exp_rv); end
         checks++; if (idle !== exp_idle) begin errors++; $display("FAIL sparse_idle c%0d got %b exp %b", c, idle, exp_idle); end
         if (c == 5 || c == 8) begin
            checks++; if (bus.res_sum !== 32'(c - 4)) begin errors++; $display("FAIL sparse_sum c%0d got %h exp %h", c, bus.res_sum, 32'(c - 4)); end
         end
         cyc();
      end
   endtask

   task automatic test_prio();
      logic [3:0] exp_g;
      do_clear();
      for (int c = 0; c < 6; c++) begin
         bus.req = 4'b1110;
         #1;
`ifdef PIPE_ADDER_ARB_FIXED_PRIO_EN
         exp_g = 4'b0010;
`else
         exp_g = 4'b0010 << (c % 3);
`endif
         checks++; if (bus.gnt !== exp_g) begin errors++; $display("FAIL prio_gnt c%0d got %b exp %b", c, bus.gnt, exp_g); end
         cyc();
      end
      quiet_inputs();
   endtask

   initial begin
      clear = 1'b0;
      quiet_inputs();
      test_reset();
      test_single();
      test_contention();
      test_carry();
      test_clear_midflight();
      test_sparse();
      test_prio();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
